// File: rtl/gmii_rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_rx_frame_ctrl_if
//  Description : GMII receive input bundle plus framed byte-stream and status
//                outputs of the receive frame controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gmii_rx_frame_ctrl_if #(
   parameter int CNT_W = 16
);
   // GMII side, driven by the receiver front end
   logic              rx_en;
   logic              gmii_rx_dv;
   logic [7:0]        gmii_rxd;

   // Framed byte stream and status toward the consumer
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_sof;
   logic              rx_eof;
   logic              rx_err;
   logic [15:0]       rx_len;
   logic              busy;
   logic [CNT_W-1:0]  frame_ok_cnt;
   logic [CNT_W-1:0]  frame_err_cnt;

   // Source of GMII bytes / consumer of the frame stream
   modport master (
      output rx_en, gmii_rx_dv, gmii_rxd,
      input  rx_valid, rx_data, rx_sof, rx_eof, rx_err, rx_len, busy,
             frame_ok_cnt, frame_err_cnt
   );

   // Frame controller side
   modport slave (
      input  rx_en, gmii_rx_dv, gmii_rxd,
      output rx_valid, rx_data, rx_sof, rx_eof, rx_err, rx_len, busy,
             frame_ok_cnt, frame_err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/gmii_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_rx_frame_ctrl
//  Description : GMII receive frame controller. Detects preamble/SFD, strips
//                them, delivers frame bytes with sof/eof/err/len two cycles
//                after input and keeps saturating good/bad frame counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module gmii_rx_frame_ctrl #(
   parameter int PRE_MIN = 1,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518,
   parameter int CNT_W   = 16
) (
   input  wire logic             gmii_rx_clk,
   input  wire logic             gmii_rx_rst,
   gmii_rx_frame_ctrl_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2,
      S_DROP = 2'd3
   } state_t;

   localparam logic [7:0]         c_PREAMBLE = 8'h55;
   localparam logic [7:0]         c_SFD      = 8'hD5;
   localparam int                 c_PRE_W    = $clog2(PRE_MIN + 1);
   localparam logic [c_PRE_W-1:0] c_PRE_MIN  = c_PRE_W'(PRE_MIN);
   localparam logic [15:0]        c_MIN_LEN  = 16'(MIN_LEN);
   localparam logic [15:0]        c_MAX_LEN  = 16'(MAX_LEN);
   localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};

   state_t             state_q, state_d;
   logic [c_PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [15:0]        len_q, len_d;      // bytes loaded since SFD; hold is full when non-zero
   logic [7:0]         hold_q, hold_d;    // newest byte, held back so eof can mark it
   logic               valid_q, valid_d;
   logic [7:0]         data_q, data_d;
   logic               sof_q, sof_d;
   logic               eof_q, eof_d;
   logic               err_q, err_d;
   logic [15:0]        olen_q, olen_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   ok_cnt_q, ok_cnt_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic               ok_inc, err_inc;

   // Next-state, output and counter decode for the frame sequencer
   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      len_d     = len_q;
      hold_d    = hold_q;
      valid_d   = 1'b0;
      data_d    = 8'h00;
      sof_d     = 1'b0;
      eof_d     = 1'b0;
      err_d     = 1'b0;
      olen_d    = 16'd0;
      ok_inc    = 1'b0;
      err_inc   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.rx_en && bus.gmii_rx_dv) begin
               if (bus.gmii_rxd == c_PREAMBLE) begin
                  state_d   = S_PRE;
                  pre_cnt_d = c_PRE_W'(1);
               end else begin
                  state_d = S_DROP;
                  err_inc = 1'b1;
               end
            end
         end

         S_PRE: begin
            if (!bus.gmii_rx_dv) begin
               state_d = S_IDLE;
               err_inc = 1'b1;
            end else if (bus.gmii_rxd == c_PREAMBLE) begin
               if (pre_cnt_q < c_PRE_MIN) pre_cnt_d = pre_cnt_q + c_PRE_W'(1);
            end else if ((bus.gmii_rxd == c_SFD) && (pre_cnt_q >= c_PRE_MIN)) begin
               state_d = S_DATA;
               len_d   = 16'd0;
            end else begin
               state_d = S_DROP;
               err_inc = 1'b1;
            end
         end

         S_DATA: begin
            if (bus.gmii_rx_dv) begin
               if (len_q == c_MAX_LEN) begin
                  // Oversize: close the frame on byte MAX_LEN and discard the rest
                  valid_d = 1'b1;
                  data_d  = hold_q;
                  sof_d   = (len_q == 16'd1);
                  eof_d   = 1'b1;
                  err_d   = 1'b1;
                  olen_d  = len_q;
                  err_inc = 1'b1;
                  state_d = S_DROP;
               end else begin
                  hold_d = bus.gmii_rxd;
                  len_d  = len_q + 16'd1;
                  if (len_q != 16'd0) begin
                     valid_d = 1'b1;
                     data_d  = hold_q;
                     sof_d   = (len_q == 16'd1);
                  end
               end
            end else begin
               state_d = S_IDLE;
               if (len_q == 16'd0) begin
                  err_inc = 1'b1;
               end else begin
                  valid_d = 1'b1;
                  data_d  = hold_q;
                  sof_d   = (len_q == 16'd1);
                  eof_d   = 1'b1;
                  err_d   = (len_q < c_MIN_LEN);
                  olen_d  = len_q;
                  ok_inc  = (len_q >= c_MIN_LEN);
                  err_inc = (len_q < c_MIN_LEN);
               end
            end
         end

         S_DROP: begin
            if (!bus.gmii_rx_dv) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      busy_d    = (state_d != S_IDLE);
      ok_cnt_d  = (ok_inc  && (ok_cnt_q  != c_CNT_MAX)) ? ok_cnt_q  + CNT_W'(1) : ok_cnt_q;
      err_cnt_d = (err_inc && (err_cnt_q != c_CNT_MAX)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
   end

   // State, datapath and output registers
   always_ff @(posedge gmii_rx_clk) begin
      if (gmii_rx_rst) begin
         state_q   <= S_IDLE;
         pre_cnt_q <= '0;
         len_q     <= 16'd0;
         hold_q    <= 8'h00;
         valid_q   <= 1'b0;
         data_q    <= 8'h00;
         sof_q     <= 1'b0;
         eof_q     <= 1'b0;
         err_q     <= 1'b0;
         olen_q    <= 16'd0;
         busy_q    <= 1'b0;
         ok_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         len_q     <= len_d;
         hold_q    <= hold_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         sof_q     <= sof_d;
         eof_q     <= eof_d;
         err_q     <= err_d;
         olen_q    <= olen_d;
         busy_q    <= busy_d;
         ok_cnt_q  <= ok_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.rx_valid      = valid_q;
   assign bus.rx_data       = data_q;
   assign bus.rx_sof        = sof_q;
   assign bus.rx_eof        = eof_q;
   assign bus.rx_err        = err_q;
   assign bus.rx_len        = olen_q;
   assign bus.busy          = busy_q;
   assign bus.frame_ok_cnt  = ok_cnt_q;
   assign bus.frame_err_cnt = err_cnt_q;
endmodule
`default_nettype wire
